// File: rtl/factor_stream_engine_if.sv
// Handshake bundle between the operand source, the factor engine and the
// display sequencer: operand in, factor stream out, plus completion status.
interface factor_stream_engine_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_factor;
  logic             done;
  logic             is_prime;
  logic             busy;

  modport master (
    output in_valid, in_value, in_mode, out_ready,
    input  in_ready, out_valid, out_factor, done, is_prime, busy
  );

  modport slave (
    input  in_valid, in_value, in_mode, out_ready,
    output in_ready, out_valid, out_factor, done, is_prime, busy
  );
endinterface

// File: rtl/factor_stream_engine.sv
// Trial-division factoriser: streams prime factors (with multiplicity) or all
// proper divisors of an operand, using one WIDTH-cycle restoring divider.
module factor_stream_engine #(
  parameter int WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  factor_stream_engine_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, DIV, CHECK, EMIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   n_cur_q, n_cur_d;
  logic [WIDTH-1:0]   n_orig_q, n_orig_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_factor_q, out_factor_d;
  logic [WIDTH-1:0]   emit_cnt_q, emit_cnt_d;
  logic               is_prime_q, is_prime_d;

  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   d_inc;
  logic               finish;

  always_comb begin
    state_d      = state_q;
    n_cur_d      = n_cur_q;
    n_orig_d     = n_orig_q;
    d_d          = d_q;
    mode_d       = mode_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    out_factor_d = out_factor_q;
    emit_cnt_d   = emit_cnt_q;
    is_prime_d   = is_prime_q;
    finish       = 1'b0;

    // Dividend bits shift out of quo_q into the partial remainder; quotient bits shift in.
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    d_inc     = d_q + WIDTH'(1);

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          n_cur_d    = bus.in_value;
          n_orig_d   = bus.in_value;
          mode_d     = bus.in_mode;
          d_d        = WIDTH'(2);
          is_prime_d = 1'b0;
          emit_cnt_d = '0;
          quo_d      = bus.in_value;
          rem_d      = '0;
          cnt_d      = '0;
          if (bus.in_value <= WIDTH'(1)) begin
            state_d = DONE;
          end else if (bus.in_mode && bus.in_value == WIDTH'(2)) begin
            state_d    = DONE;
            is_prime_d = 1'b1;
          end else begin
            state_d = DIV;
          end
        end
      end

      DIV: begin
        if (rem_shift >= {1'b0, d_q}) begin
          rem_d = rem_shift[WIDTH-1:0] - d_q;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        quo_d = n_cur_q;
        rem_d = '0;
        cnt_d = '0;
        if (!mode_q) begin
          if (rem_q == '0) begin
            out_factor_d = d_q;
            n_cur_d      = quo_q;
            state_d      = EMIT;
          end else if (quo_q < d_q) begin
            // No divisor up to sqrt(n_cur) remains, so n_cur itself is prime.
            out_factor_d = n_cur_q;
            n_cur_d      = WIDTH'(1);
            state_d      = EMIT;
          end else begin
            d_d     = d_inc;
            state_d = DIV;
          end
        end else begin
          d_d = d_inc;
          if (rem_q == '0) begin
            out_factor_d = d_q;
            state_d      = EMIT;
          end else if (d_inc >= n_orig_q) begin
            state_d    = DONE;
            is_prime_d = (emit_cnt_q == '0) && (n_orig_q >= WIDTH'(2));
          end else begin
            state_d = DIV;
          end
        end
      end

      EMIT: begin
        if (bus.out_ready) begin
          emit_cnt_d = emit_cnt_q + WIDTH'(1);
          quo_d      = n_cur_q;
          rem_d      = '0;
          cnt_d      = '0;
          finish     = mode_q ? (d_q >= n_orig_q) : (n_cur_q == WIDTH'(1));
          if (finish) begin
            state_d    = DONE;
            is_prime_d = !mode_q && (emit_cnt_q == '0) && (out_factor_q == n_orig_q);
          end else begin
            state_d = DIV;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      n_cur_q      <= '0;
      n_orig_q     <= '0;
      d_q          <= '0;
      mode_q       <= 1'b0;
      quo_q        <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      out_factor_q <= '0;
      emit_cnt_q   <= '0;
      is_prime_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_cur_q      <= n_cur_d;
      n_orig_q     <= n_orig_d;
      d_q          <= d_d;
      mode_q       <= mode_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      out_factor_q <= out_factor_d;
      emit_cnt_q   <= emit_cnt_d;
      is_prime_q   <= is_prime_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == EMIT);
  assign bus.out_factor = out_factor_q;
  assign bus.done       = (state_q == DONE);
  assign bus.is_prime   = is_prime_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: doc/factor_stream_engine.md
# factor_stream_engine

Parametrised sequential factorisation core for the Tiny Tapeout factorizer top level. It accepts a WIDTH-bit operand over a valid/ready handshake and computes factors by trial division on a shared restoring divider. In PRIME mode it streams the prime factorisation with multiplicity. In DIVISOR mode it streams every proper divisor. Factors go out one per handshake to the display sequencer, followed by a `done` pulse and an `is_prime` flag.

## Interface
- `WIDTH`, default 16: operand, factor and divider width (≥4).
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `in_valid` in 1: operand offered.
- `in_ready` out 1: engine idle, so an operand can be accepted; equals state==IDLE.
- `in_value` in WIDTH: operand N, unsigned.
- `in_mode` in 1: 0 = PRIME, 1 = DIVISOR; sampled at accept.
- `out_valid` out 1: factor available.
- `out_ready` in 1: consumer accepts the factor.
- `out_factor` out WIDTH: current factor; held stable while `out_valid` is high.
- `done` out 1: one-cycle pulse after the final factor, or after accept if there are no factors.
- `is_prime` out 1: result flag; valid from `done` until the next accept.
- `busy` out 1: high from accept through the `done` cycle.

## Operation
- States: IDLE, DIV, CHECK, EMIT, DONE.
- IDLE
  - `in_valid & in_ready` latches: N → n_cur and n_orig, the mode, d = 2, and clears `is_prime` and the emit counter.
  - If N ≤ 1, go to DONE.
  - Otherwise go to DIV.
- DIV: restoring division n_cur / d, one quotient bit per cycle, exactly WIDTH cycles, giving q and r.
- CHECK, PRIME mode:
  - r == 0: out_factor = d, n_cur ← q, go to EMIT; d is unchanged.
  - r ≠ 0 and q < d: out_factor = n_cur, n_cur ← 1, go to EMIT. This covers the remaining prime cofactor.
  - Otherwise: d ← d + 1, go to DIV.
- CHECK, DIVISOR mode:
  - r == 0: out_factor = d, go to EMIT.
  - Then d ← d + 1 in either case.
  - If the new d ≥ n_orig, the path ends after any EMIT and goes to DONE; otherwise it continues to DIV.
- EMIT
  - Holds `out_valid` = 1 and `out_factor` stable until `out_ready`; there is no timeout.
  - On the handshake, increment the emit counter, then choose the next state:
    - PRIME: n_cur == 1 → DONE, else DIV.
    - DIVISOR: d ≥ n_orig → DONE, else DIV.
- DIVISOR-mode entry check: if d = 2 ≥ n_orig (N = 2), go straight to DONE without a trial.
- DONE
  - `done` = 1 for one cycle, then IDLE.
  - `is_prime` is registered here:
    - PRIME: 1 iff exactly one factor was emitted and it equals n_orig.
    - DIVISOR: 1 iff zero factors were emitted and n_orig ≥ 2.
  - N = 0 or N = 1: no factors and `is_prime` = 0 in both modes.
- Arithmetic: d, q and n_cur are WIDTH bits. The increment of d cannot overflow because d ≤ n_orig ≤ 2^WIDTH−1.
- `in_valid` outside IDLE is ignored, with no queuing. `in_value` and `in_mode` changes mid-operation have no effect.

## Timing
- Reset (`rst_n` low at an edge): state = IDLE, `in_ready` = 1, `out_valid` = 0, `out_factor` = 0, `done` = 0, `is_prime` = 0, `busy` = 0, internal registers cleared. This applies mid-operation too; any pending factor is dropped.
- Accept edge = cycle 0. First DIV cycle = cycle 1. Each trial = WIDTH DIV cycles + 1 CHECK cycle.
- EMIT: `out_valid` rises the cycle after CHECK and drops the cycle after the handshake. It lasts ≥1 cycle, exactly 1 with `out_ready` held high.
- DONE occupies the cycle after the last EMIT handshake, or after the last CHECK if nothing was emitted. `in_ready` returns the following cycle.
- N ≤ 1 or DIVISOR N = 2: `done` in cycle 1.
- Back-to-back operands: the earliest new accept is the cycle after DONE.

## Test plan
- Reset:
  - Stimulus: hold `rst_n` low 2 cycles, then release.
  - Required: all outputs at reset values and `in_ready` = 1 in the first cycle after release.
- PRIME, prime operand:
  - Stimulus: WIDTH = 16, PRIME N = 7, `out_ready` = 1.
  - Required: single factor 7 with `out_valid` in cycle 35; `done` in cycle 36; `is_prime` = 1.
- PRIME, repeated factors:
  - Stimulus: PRIME N = 360.
  - Required: factor stream 2, 2, 2, 3, 3, 5, then `done`; `is_prime` = 0.
  - Stimulus: PRIME N = 65521.
  - Required: single factor 65521; `is_prime` = 1.
- DIVISOR mode:
  - Stimulus: DIVISOR N = 12.
  - Required: stream 2, 3, 4, 6, then `done`; `is_prime` = 0.
  - Stimulus: DIVISOR N = 13.
  - Required: no `out_valid`; `done` pulse; `is_prime` = 1.
- Boundaries and backpressure:
  - Stimulus: N = 0, then N = 1, in both modes.
  - Required: `done` in cycle 1, no factors, `is_prime` = 0.
  - Stimulus: PRIME N = 4 with `out_ready` low 5 cycles per factor.
  - Required: factor 2 held stable across the stall, emitted twice in total.
- Mid-operation events:
  - Stimulus: `in_valid` pulsed while busy.
  - Required: ignored; the result is unaffected.
  - Stimulus: `rst_n` asserted during EMIT of N = 360.
  - Required: `out_valid` = 0 the next cycle and IDLE.
  - Stimulus: a fresh N = 9 afterwards.
  - Required: stream 3, 3.
